exec_alu_stage: RTL and testbench
=================================

# exec_alu_stage

Two-deep pipelined execute stage for the scalar processor. It accepts a decoded operation from issue/decode: opcode, two 12-bit operands and a destination register index. It computes the result on the low 8 bits, including the 8-bit subtract path, and holds it in an EX/WB register for writeback. Handshakes are valid/ready on both sides, with flush support for branch redirects.

## Interface
- `DATA_W`, 12: operand/result width on the datapath bus.
- `ALU_W`, 8: active arithmetic width. Bits [DATA_W-1:ALU_W] of every result are 0.
- `RD_W`, 3: destination register index width.

- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on `clk` rising edge.
- `flush`  in  1  synchronous pipeline kill.
- `in_valid`  in  1  upstream operation valid.
- `in_ready`  out  1  stage can accept this cycle.
- `in_opcode`  in  3  operation select.
- `in_op1`  in  DATA_W  operand A.
- `in_op2`  in  DATA_W  operand B.
- `in_rd`  in  RD_W  destination register.
- `out_valid`  out  1  result valid for writeback.
- `out_ready`  in  1  writeback accepts.
- `out_result`  out  DATA_W  result, upper bits zero.
- `out_rd`  out  RD_W  destination register.
- `out_carry`  out  1  carry / no-borrow flag.
- `out_zero`  out  1  result[ALU_W-1:0] == 0.

## Operation
- Stage S1 is the operand latch: opcode, op1, op2, rd and `s1_valid`. Stage S2 is the result latch: result, rd, carry, zero and `s2_valid`.
- ALU is evaluated combinationally between S1 and S2, on op[ALU_W-1:0] only.
- Opcodes:
  - 000 ADD: A+B, carry = carry-out of bit 7.
  - 001 SUB: A + ~B + 1, carry = C[8]. Carry is 1 iff A ≥ B unsigned (no borrow).
  - 010 AND, 011 OR, 100 XOR: carry = 0.
  - 101 SHL: A << B[2:0], carry = 0.
  - 110 SHR: A >> B[2:0], logical, carry = 0.
  - 111 PASS: B, carry = 0.
- Operand bits [11:8] are ignored. `out_result[11:8]` = 0 always.
- Advance rules:
  - `s2_adv = s1_valid & (!s2_valid | out_ready)`.
  - `in_ready = rst_n & !flush & (!s1_valid | s2_adv)`.
  - Accept = `in_valid & in_ready`.
- Transfer on `out_valid & out_ready`. If S2 is drained while S1 is empty, `s2_valid` clears.
- `flush` = 1: both valids clear at that edge, no input accepted, and in-flight results are discarded. `flush` overrides a same-cycle `out_ready` handshake; the item held at S2 is treated as killed.
- Reset (`rst_n` = 0 at edge): `s1_valid` = `s2_valid` = 0, all S2 data registers = 0.
- Reset output values: `out_valid` = 0, `out_result` = 0x000, `out_rd` = 0, `out_carry` = 0, `out_zero` = 0, `in_ready` = 0 while `rst_n` low.
- Reset dominates `flush`. Reset mid-stream drops all in-flight operations.

## Timing
- Latency: an operation accepted at edge N is loaded into S1 at N and S2 at N+1. `out_valid` = 1 in the cycle after N+1 when not stalled.
- Throughput: 1 op/cycle with `out_ready` held 1.
- `in_ready` is combinational from state, `out_ready` and `flush`. There is no combinational path from `in_valid` to `in_ready`.
- While `out_valid & !out_ready`, all `out_*` signals stay stable.
- Full condition (both stages valid, `out_ready` = 0): `in_ready` = 0. At most 2 operations are buffered.
- Simultaneous accept and drain with both stages full: S1 moves to S2, the new op enters S1, and no bubble is inserted.
- Data registers load only on valid transfer. When nothing advances, they hold their value; they are never cleared by `flush`.

## Structure
- Package `exec_pkg`:
  - opcode localparams (`OP_ADD` … `OP_PASS`)
  - `DATA_W`, `ALU_W`, `RD_W` defaults
  - a packed struct for the S1 payload
- One sub-module, `exec_alu8`: combinational 8-bit ALU with a carry-lookahead add/sub. Inputs are opcode, a, b; outputs are result[7:0] and carry.
- The top level holds only the two pipeline registers and the handshake logic.

## Test plan
- Reset: hold `rst_n` = 0 for 3 cycles with `in_valid` = 1 and opcode SUB. Expect `out_valid` = 0, `out_result` = 0x000 and `in_ready` = 0 throughout. Expect `in_ready` = 1 in the first cycle after release.
- SUB:
  - 0x0A5 − 0x023 → 0x082, carry = 1, zero = 0.
  - 0x010 − 0x020 → 0x0F0, carry = 0.
  - 0xF05 − 0xA05 → 0x000, carry = 1, zero = 1.
  - Each result has `out_valid` 2 edges after accept.
- ADD/shift:
  - 0x0FF + 0x001 → 0x000, carry = 1, zero = 1.
  - SHL 0x081 by 0x003 → 0x008.
  - SHR 0x080 by 0x007 → 0x001.
  - PASS 0x7AB → 0x0AB.
- Backpressure: hold `out_ready` = 0 and offer ADD ops with rd = 1, 2, 3. Only rd 1 and 2 are accepted, then `in_ready` = 0. Raise `out_ready`: results emerge in order 1, 2, 3, with no duplicate or loss and one per cycle.
- Flush: with both stages valid and `out_ready` = 0, pulse `flush` for 1 cycle. Next cycle `out_valid` = 0 and `in_ready` = 1. The flushed rd values never appear on the output.
- Streaming: 16 back-to-back random ops with `out_ready` = 1. Expect zero bubbles and all results equal to the reference model with [11:8] = 0.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: widths, opcode encodings and the
// S1 operand-latch payload.
package exec_pkg;

  localparam int unsigned DATA_W = 12;
  localparam int unsigned ALU_W  = 8;
  localparam int unsigned RD_W   = 3;
  localparam int unsigned OP_W   = 3;

  localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
  localparam logic [OP_W-1:0] OP_AND  = 3'b010;
  localparam logic [OP_W-1:0] OP_OR   = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR  = 3'b100;
  localparam logic [OP_W-1:0] OP_SHL  = 3'b101;
  localparam logic [OP_W-1:0] OP_SHR  = 3'b110;
  localparam logic [OP_W-1:0] OP_PASS = 3'b111;

  // Only the active ALU bits of each operand are kept; the upper bits never
  // influence the result.
  typedef struct packed {
    logic [OP_W-1:0]  opcode;
    logic [ALU_W-1:0] op_a;
    logic [ALU_W-1:0] op_b;
    logic [RD_W-1:0]  rd;
  } s1_payload_t;

endpackage

// File: rtl/exec_alu8.sv
// Combinational 8-bit ALU with a two-group carry-lookahead adder shared by
// ADD and SUB.
//   opcode : operation select (exec_pkg OP_*)
//   a, b   : 8-bit operands
//   result : 8-bit result
//   carry  : ADD carry-out / SUB no-borrow, 0 for all other operations
module exec_alu8
  import exec_pkg::*;
(
  input  logic [OP_W-1:0]  opcode,
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  output logic [ALU_W-1:0] result,
  output logic             carry
);

  // Carries into bit positions 1..4 of a 4-bit group, fully looked ahead.
  function automatic logic [3:0] cla4(input logic [3:0] g,
                                      input logic [3:0] p,
                                      input logic       cin);
    logic [3:0] c;
    c[0] = g[0] | (p[0] & cin);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
    c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
    return c;
  endfunction

  logic             is_sub;
  logic [ALU_W-1:0] b_eff;
  logic [ALU_W-1:0] gen;
  logic [ALU_W-1:0] prop;
  logic [3:0]       c_lo;
  logic [3:0]       c_hi;
  logic [ALU_W:0]   carries;
  logic [ALU_W-1:0] sum;

  // SUB is A + ~B + 1: invert B and feed the +1 in as carry-in.
  assign is_sub  = (opcode == OP_SUB);
  assign b_eff   = is_sub ? ~b : b;
  assign gen     = a & b_eff;
  assign prop    = a ^ b_eff;
  assign c_lo    = cla4(gen[3:0], prop[3:0], is_sub);
  assign c_hi    = cla4(gen[7:4], prop[7:4], c_lo[3]);
  assign carries = {c_hi, c_lo, is_sub};
  assign sum     = prop ^ carries[ALU_W-1:0];

  // Operation select.
  always_comb begin
    result = sum;
    carry  = 1'b0;
    case (opcode)
      OP_ADD,
      OP_SUB:  begin
        result = sum;
        carry  = carries[ALU_W];
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SHL:  result = a << b[2:0];
      OP_SHR:  result = a >> b[2:0];
      OP_PASS: result = b;
      default: result = sum;
    endcase
  end

endmodule

// File: rtl/exec_alu_stage.sv
// Two-deep pipelined execute stage: S1 latches the decoded operation, the ALU
// sits between S1 and S2, and S2 holds the result for writeback.
//   clk, rst_n          : clock, synchronous active-low reset
//   flush               : kills both stages at the next edge
//   in_valid/in_ready   : upstream handshake
//   in_opcode/op1/op2/rd: decoded operation
//   out_valid/out_ready : writeback handshake
//   out_result/rd/carry/zero : registered S2 result, result[11:8] always 0
module exec_alu_stage
  import exec_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_opcode,
  input  logic [DATA_W-1:0] in_op1,
  input  logic [DATA_W-1:0] in_op2,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_carry,
  output logic              out_zero
);

  logic              s1_valid;
  s1_payload_t       s1_q;
  logic              s2_valid;
  logic [DATA_W-1:0] s2_result;
  logic [RD_W-1:0]   s2_rd;
  logic              s2_carry;
  logic              s2_zero;

  logic              s2_adv;
  logic              accept;
  logic [ALU_W-1:0]  alu_result;
  logic              alu_carry;
  logic              unused_op_hi;

  // Upper operand bits are architecturally ignored.
  assign unused_op_hi = ^{in_op1[DATA_W-1:ALU_W], in_op2[DATA_W-1:ALU_W]};

  // Handshake: S1 may move into S2 when S2 is empty or draining.
  assign s2_adv   = s1_valid & (~s2_valid | out_ready);
  assign in_ready = rst_n & ~flush & (~s1_valid | s2_adv);
  assign accept   = in_valid & in_ready;

  exec_alu8 u_alu (
    .opcode (s1_q.opcode),
    .a      (s1_q.op_a),
    .b      (s1_q.op_b),
    .result (alu_result),
    .carry  (alu_carry)
  );

  // S1 operand latch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else begin
      if (flush)       s1_valid <= 1'b0;
      else if (accept) s1_valid <= 1'b1;
      else if (s2_adv) s1_valid <= 1'b0;

      if (accept) begin
        s1_q <= '{opcode: in_opcode,
                  op_a:   in_op1[ALU_W-1:0],
                  op_b:   in_op2[ALU_W-1:0],
                  rd:     in_rd};
      end
    end
  end

  // S2 result latch; flush kills the held item even if out_ready is high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_rd     <= '0;
      s2_carry  <= 1'b0;
      s2_zero   <= 1'b0;
    end else begin
      if (flush)          s2_valid <= 1'b0;
      else if (s2_adv)    s2_valid <= 1'b1;
      else if (out_ready) s2_valid <= 1'b0;

      if (s2_adv && !flush) begin
        s2_result <= DATA_W'(alu_result);
        s2_rd     <= s1_q.rd;
        s2_carry  <= alu_carry;
        s2_zero   <= (alu_result == '0);
      end
    end
  end

  assign out_valid  = s2_valid;
  assign out_result = s2_result;
  assign out_rd     = s2_rd;
  assign out_carry  = s2_carry;
  assign out_zero   = s2_zero;

endmodule

// File: tb/tb_exec_alu_stage.sv
// Self-checking bench for exec_alu_stage: directed vector table, then
// backpressure, flush, mid-stream reset and streaming sequences.
module tb_exec_alu_stage;
  import exec_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_opcode;
  logic [DATA_W-1:0] in_op1;
  logic [DATA_W-1:0] in_op2;
  logic [RD_W-1:0]   in_rd;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [RD_W-1:0]   out_rd;
  logic              out_carry;
  logic              out_zero;

  int errors = 0;
  int checks = 0;

  exec_alu_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_op1     (in_op1),
    .in_op2     (in_op2),
    .in_rd      (in_rd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .out_carry  (out_carry),
    .out_zero   (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  op;
    logic [11:0] a;
    logic [11:0] b;
    logic [2:0]  rd;
    logic [11:0] res;
    logic        c;
    logic        z;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  logic [2:0]  s_op [16];
  logic [11:0] s_a  [16];
  logic [11:0] s_b  [16];
  logic [2:0]  s_rd [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [11:0] a,
                       input logic [11:0] b, input logic [2:0] rd);
    in_valid  = 1'b1;
    in_opcode = op;
    in_op1    = a;
    in_op2    = b;
    in_rd     = rd;
  endtask

  // Reference: {carry, result[7:0]} computed with plain arithmetic.
  function automatic logic [8:0] ref_alu(input logic [2:0] op,
                                         input logic [11:0] a,
                                         input logic [11:0] b);
    logic [7:0] x;
    logic [7:0] y;
    x = a[7:0];
    y = b[7:0];
    case (op)
      OP_ADD:  return {1'b0, x} + {1'b0, y};
      OP_SUB:  return {(x >= y), 8'(x - y)};
      OP_AND:  return {1'b0, x & y};
      OP_OR:   return {1'b0, x | y};
      OP_XOR:  return {1'b0, x ^ y};
      OP_SHL:  return {1'b0, 8'(x << y[2:0])};
      OP_SHR:  return {1'b0, 8'(x >> y[2:0])};
      default: return {1'b0, y};
    endcase
  endfunction

  initial begin
    vecs[0]  = '{OP_SUB,  12'h0A5, 12'h023, 3'd1, 12'h082, 1'b1, 1'b0};
    vecs[1]  = '{OP_SUB,  12'h010, 12'h020, 3'd2, 12'h0F0, 1'b0, 1'b0};
    vecs[2]  = '{OP_SUB,  12'hF05, 12'hA05, 3'd3, 12'h000, 1'b1, 1'b1};
    vecs[3]  = '{OP_ADD,  12'h0FF, 12'h001, 3'd4, 12'h000, 1'b1, 1'b1};
    vecs[4]  = '{OP_SHL,  12'h081, 12'h003, 3'd5, 12'h008, 1'b0, 1'b0};
    vecs[5]  = '{OP_SHR,  12'h080, 12'h007, 3'd6, 12'h001, 1'b0, 1'b0};
    vecs[6]  = '{OP_PASS, 12'h123, 12'h7AB, 3'd7, 12'h0AB, 1'b0, 1'b0};
    vecs[7]  = '{OP_AND,  12'h0F0, 12'h3CC, 3'd0, 12'h0C0, 1'b0, 1'b0};
    vecs[8]  = '{OP_OR,   12'h00F, 12'h0F0, 3'd1, 12'h0FF, 1'b0, 1'b0};
    vecs[9]  = '{OP_XOR,  12'h0FF, 12'h0FF, 3'd2, 12'h000, 1'b0, 1'b1};
    vecs[10] = '{OP_ADD,  12'h07F, 12'h001, 3'd3, 12'h080, 1'b0, 1'b0};
    vecs[11] = '{OP_SHL,  12'h001, 12'h00A, 3'd4, 12'h004, 1'b0, 1'b0};

    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(OP_SUB, 12'h0A5, 12'h023, 3'd1);

    // Reset held for 3 cycles with a valid SUB offered.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_out_valid",  32'(out_valid),  32'd0);
      check("rst_out_result", 32'(out_result), 32'd0);
      check("rst_in_ready",   32'(in_ready),   32'd0);
    end
    check("rst_out_rd",    32'(out_rd),    32'd0);
    check("rst_out_carry", 32'(out_carry), 32'd0);
    check("rst_out_zero",  32'(out_zero),  32'd0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);

    // Directed vectors, one at a time, with latency checks.
    for (int i = 0; i < NVEC; i++) begin
      tick();
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd);
      #1;
      check("vec_in_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      check("vec_lat_s1", 32'(out_valid), 32'd0);
      tick();
      check("vec_valid",  32'(out_valid),  32'd1);
      check("vec_result", 32'(out_result), 32'(vecs[i].res));
      check("vec_carry",  32'(out_carry),  32'(vecs[i].c));
      check("vec_zero",   32'(out_zero),   32'(vecs[i].z));
      check("vec_rd",     32'(out_rd),     32'(vecs[i].rd));
    end
    tick();
    check("idle_valid", 32'(out_valid), 32'd0);

    // Backpressure: only two ops fit, then results drain in order.
    out_ready = 1'b0;
    drive(OP_ADD, 12'h010, 12'h001, 3'd1);
    #1;
    check("bp_rdy1", 32'(in_ready), 32'd1);
    tick();
    drive(OP_ADD, 12'h020, 12'h001, 3'd2);
    #1;
    check("bp_rdy2", 32'(in_ready), 32'd1);
    tick();
    drive(OP_ADD, 12'h030, 12'h001, 3'd3);
    #1;
    check("bp_full", 32'(in_ready), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_rd",    32'(out_rd),    32'd1);
      check("bp_hold_res",   32'(out_result), 32'h011);
      check("bp_hold_rdy",   32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_rdy3", 32'(in_ready), 32'd1);
    for (int k = 1; k <= 3; k++) begin
      check("bp_drain_valid", 32'(out_valid),  32'd1);
      check("bp_drain_rd",    32'(out_rd),     32'(k));
      check("bp_drain_res",   32'(out_result), 32'(k * 16 + 1));
      tick();
      in_valid = 1'b0;
    end
    check("bp_empty", 32'(out_valid), 32'd0);

    // Flush with both stages full and a same-cycle out_ready handshake.
    out_ready = 1'b0;
    drive(OP_ADD, 12'h050, 12'h001, 3'd5);
    tick();
    drive(OP_ADD, 12'h060, 12'h001, 3'd6);
    tick();
    check("fl_pre_valid", 32'(out_valid), 32'd1);
    drive(OP_ADD, 12'h070, 12'h001, 3'd7);
    flush     = 1'b1;
    out_ready = 1'b1;
    #1;
    check("fl_in_ready", 32'(in_ready), 32'd0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("fl_post_valid", 32'(out_valid), 32'd0);
    check("fl_post_rdy",   32'(in_ready),  32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fl_no_output", 32'(out_valid), 32'd0);
    end

    // Reset mid-stream drops the in-flight op.
    drive(OP_ADD, 12'h005, 12'h006, 3'd4);
    tick();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    tick();
    check("mrst_valid",  32'(out_valid),  32'd0);
    check("mrst_result", 32'(out_result), 32'd0);
    rst_n = 1'b1;
    tick();
    check("mrst_after", 32'(out_valid), 32'd0);

    // Streaming: 16 back-to-back random ops, no bubbles.
    for (int i = 0; i < 16; i++) begin
      s_op[i] = 3'($urandom_range(0, 7));
      s_a[i]  = 12'($urandom);
      s_b[i]  = 12'($urandom);
      s_rd[i] = 3'(i);
    end
    for (int k = 0; k < 18; k++) begin
      if (k >= 2) begin
        logic [8:0]  r;
        logic [17:0] exp_v;
        r = ref_alu(s_op[k-2], s_a[k-2], s_b[k-2]);
        exp_v = {1'b1, s_rd[k-2], r[8], (r[7:0] == 8'h00), 4'h0, r[7:0]};
        check("stream", 32'({out_valid, out_rd, out_carry, out_zero, out_result}),
              32'(exp_v));
      end
      if (k < 16) begin
        drive(s_op[k], s_a[k], s_b[k], s_rd[k]);
        #1;
        check("stream_rdy", 32'(in_ready), 32'd1);
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    check("stream_end", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
